// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with a byte FIFO, CPU port registers and a level interrupt.
module uart_rx #(
    parameter int CLOCK_FREQ      = 10000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic [1:0]  ADDRESS,
    input  logic [15:0] DATA_IN,
    output logic [15:0] DATA_OUT,
    input  logic        memWR,
    input  logic        memRD,
    input  logic        rx_in,
    output logic        irq
);
    localparam int DIV   = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF  = DIV / 2;
    localparam int CW    = $clog2(DIV);
    localparam int FB    = FIFO_DEPTH_BITS;
    localparam int NW    = FB + 1;
    localparam int DEPTH = 1 << FB;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t         state, state_n;
    logic [1:0]     sync;
    logic           rxs;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     idx, idx_n;
    logic [7:0]     sh, sh_n;
    logic           push, frame_set, tick;
    logic [7:0]     mem [DEPTH];
    logic [FB-1:0]  wp, rp;
    logic [NW-1:0]  count;
    logic           full, not_empty, push_ok, pop;
    logic           overrun, frame_err, irq_en;
    logic           ov_clr, fe_clr;
    logic [15:0]    rdata;
    logic           unused;

    assign rxs       = sync[1];
    assign tick      = cnt == '0;
    assign full      = count == NW'(DEPTH);
    assign not_empty = count != '0;
    assign push_ok   = push & ~full;
    assign pop       = memRD & (ADDRESS == 2'd0) & not_empty;
    assign ov_clr    = memWR & (ADDRESS == 2'd1) & DATA_IN[2];
    assign fe_clr    = memWR & (ADDRESS == 2'd1) & DATA_IN[3];
    assign unused    = ^{DATA_IN[15:4], DATA_IN[1]};

    always_comb begin
        state_n   = state;
        cnt_n     = tick ? cnt : cnt - CW'(1);
        idx_n     = idx;
        sh_n      = sh;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: if (!rxs) begin
                state_n = START;
                cnt_n   = CW'(HALF - 1);
            end
            START: if (tick) begin
                state_n = rxs ? IDLE : DATA;
                cnt_n   = CW'(DIV - 1);
                idx_n   = '0;
            end
            DATA: if (tick) begin
                sh_n[idx] = rxs;
                idx_n     = idx + 3'd1;
                cnt_n     = CW'(DIV - 1);
                state_n   = (idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_n   = rxs ? IDLE : WAIT_HIGH;
                push      = rxs;
                frame_set = ~rxs;
            end
            WAIT_HIGH: if (rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // read mux sees pre-edge state, so a DATA read returns the head being popped
    always_comb begin
        rdata = ADDRESS == 2'd0 ? (not_empty ? {8'h00, mem[rp]} : 16'h0000) :
                ADDRESS == 2'd1 ? {12'h000, frame_err, overrun, full, not_empty} :
                ADDRESS == 2'd2 ? {15'h0000, irq_en} : 16'h0000;
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wp] <= sh;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            sync      <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
            DATA_OUT  <= '0;
        end else begin
            sync      <= {sync[0], rx_in};
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            wp        <= push_ok ? wp + FB'(1) : wp;
            rp        <= pop ? rp + FB'(1) : rp;
            count     <= count + NW'(push_ok) - NW'(pop);
            overrun   <= (push & full) | (overrun & ~ov_clr);
            frame_err <= frame_set | (frame_err & ~fe_clr);
            irq_en    <= (memWR && ADDRESS == 2'd2) ? DATA_IN[0] : irq_en;
            irq       <= irq_en & (not_empty | overrun | frame_err);
            DATA_OUT  <= memRD ? rdata : DATA_OUT;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames and register accesses checked against a queue-based receiver model.
module tb_uart_rx;
    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic [1:0]  ADDRESS = 2'd0;
    logic [15:0] DATA_IN = 16'h0;
    logic [15:0] DATA_OUT;
    logic        memWR = 1'b0;
    logic        memRD = 1'b0;
    logic        rx_in = 1'b1;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // a frame whose start bit is driven just after edge 0 has its stop bit sampled at edge 820
    localparam int BIT = 86;
    localparam int STOP_EDGE = 3 + 43 + 9 * BIT;

    logic [7:0]  q[$];
    logic        ov_m = 0, fe_m = 0, ien_m = 0, irq_m = 0;
    logic [15:0] dout_m = 0;
    int          pend = 0;
    logic [7:0]  pbyte = 0;
    logic        pstop = 1;

    uart_rx dut (
        .CLK(CLK), .RSTb(RSTb), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT), .memWR(memWR), .memRD(memRD), .rx_in(rx_in), .irq(irq)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RSTb) begin
        bit ne, full, push, fset;
        if (!RSTb) begin
            q.delete();
            ov_m = 0; fe_m = 0; ien_m = 0; irq_m = 0; dout_m = 0; pend = 0;
        end else begin
            ne   = q.size() != 0;
            full = q.size() == 16;
            push = 0;
            fset = 0;
            irq_m = ien_m & (ne | ov_m | fe_m);
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    push = pstop;
                    fset = !pstop;
                end
            end
            if (memRD)
                dout_m = ADDRESS == 0 ? (ne ? {8'h00, q[0]} : 16'h0) :
                         ADDRESS == 1 ? {12'h0, fe_m, ov_m, full, ne} :
                         ADDRESS == 2 ? {15'h0, ien_m} : 16'h0;
            if (memWR && ADDRESS == 1 && DATA_IN[2]) ov_m = 0;
            if (memWR && ADDRESS == 1 && DATA_IN[3]) fe_m = 0;
            if (push && full) ov_m = 1;
            if (fset) fe_m = 1;
            if (memWR && ADDRESS == 2) ien_m = DATA_IN[0];
            if (memRD && ADDRESS == 0 && ne) void'(q.pop_front());
            if (push && !full) q.push_back(pbyte);
        end
    end

    always @(negedge CLK) begin
        checks = checks + 2;
        if (DATA_OUT !== dout_m) begin
            errors++;
            if (errors < 30) $display("FAIL model_dout t=%0t: got %h expected %h", $time, DATA_OUT, dout_m);
        end
        if (irq !== irq_m) begin
            errors++;
            if (errors < 30) $display("FAIL model_irq t=%0t: got %b expected %b", $time, irq, irq_m);
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string nm);
        ADDRESS = a;
        memRD = 1;
        idle(1);
        memRD = 0;
        chk(nm, DATA_OUT, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        ADDRESS = a;
        DATA_IN = d;
        memWR = 1;
        idle(1);
        memWR = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int stop_len);
        pbyte = b;
        pstop = stop;
        pend = STOP_EDGE;
        rx_in = 0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            idle(BIT);
        end
        rx_in = stop;
        idle(stop_len);
        rx_in = 1;
        idle(20);
    endtask

    initial begin
        idle(3);
        RSTb = 1;
        idle(2);
        chk("reset_dout", DATA_OUT, 16'h0000);
        chk("reset_irq", {15'h0, irq}, 16'h0000);
        rd(2'd1, 16'h0000, "reset_status");

        send(8'h55, 1, BIT);
        rd(2'd1, 16'h0001, "status_55");
        rd(2'd0, 16'h0055, "data_55");
        rd(2'd1, 16'h0000, "status_after_55");

        rx_in = 0;
        idle(20);
        rx_in = 1;
        idle(200);
        rd(2'd1, 16'h0000, "glitch_status");

        send(8'hA3, 0, 200);
        idle(1000);
        rd(2'd1, 16'h0008, "frame_err_status");
        wr(2'd1, 16'h0008);
        rd(2'd1, 16'h0000, "frame_err_cleared");
        send(8'h3C, 1, BIT);
        rd(2'd0, 16'h003C, "data_3c");

        for (int i = 0; i < 17; i++) send(8'(i), 1, BIT);
        rd(2'd1, 16'h0007, "overrun_status");
        for (int i = 0; i < 16; i++) rd(2'd0, {8'h00, 8'(i)}, "drain_seq");
        rd(2'd0, 16'h0000, "empty_read");
        wr(2'd1, 16'h0004);
        rd(2'd1, 16'h0000, "overrun_cleared");

        wr(2'd2, 16'h0001);
        rd(2'd2, 16'h0001, "control_rd");
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1, BIT);
        chk("irq_full", {15'h0, irq}, 16'h0001);
        fork
            send(8'h77, 1, BIT);
            begin
                idle(STOP_EDGE - 1);
                ADDRESS = 2'd0;
                memRD = 1;
                idle(1);
                memRD = 0;
                chk("race_pop", DATA_OUT, 16'h0020);
            end
        join
        rd(2'd1, 16'h0005, "race_status");
        chk("irq_overrun", {15'h0, irq}, 16'h0001);
        wr(2'd1, 16'h0004);
        for (int i = 1; i < 16; i++) rd(2'd0, {8'h00, 8'h20 + 8'(i)}, "drain_race");
        chk("irq_lag", {15'h0, irq}, 16'h0001);
        idle(1);
        chk("irq_drop", {15'h0, irq}, 16'h0000);
        rd(2'd1, 16'h0000, "drained_status");

        rx_in = 0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            idle(BIT);
        end
        rx_in = 1;
        idle(40);
        RSTb = 0;
        idle(3);
        RSTb = 1;
        idle(50);
        send(8'h81, 1, BIT);
        rd(2'd0, 16'h0081, "data_81");
        rd(2'd1, 16'h0000, "status_after_reset");
        chk("irq_after_reset", {15'h0, irq}, 16'h0000);
        rd(2'd2, 16'h0000, "control_after_reset");
        rd(2'd3, 16'h0000, "addr3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
